// File: rtl/repl_pkg.sv
// rtl/repl_pkg.sv - shared constants, width helpers and FSM encoding for the replacement unit
package repl_pkg;

    localparam int MODE_FIFO = 0;
    localparam int MODE_LRU  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // One set's ages packed as WAYS fields of clog2(WAYS) bits, way 0 in the LSBs.
    function automatic int age_vec_w(input int ways);
        return ways * clog2(ways);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_COMMIT
    } repl_state_e;

endpackage

// File: rtl/repl_age_update.sv
// rtl/repl_age_update.sv - makes one way newest while keeping the set's ages a permutation
module repl_age_update
    import repl_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [age_vec_w(WAYS)-1:0] ages_in,
    input  logic [clog2(WAYS)-1:0]     way,
    output logic [age_vec_w(WAYS)-1:0] ages_out
);

    localparam int IDX_W = clog2(WAYS);

    logic [IDX_W-1:0] ref_age;

    always_comb begin
        ref_age  = ages_in[int'(way)*IDX_W +: IDX_W];
        ages_out = ages_in;
        for (int u = 0; u < WAYS; u++) begin
            if (ages_in[u*IDX_W +: IDX_W] < ref_age) begin
                ages_out[u*IDX_W +: IDX_W] = ages_in[u*IDX_W +: IDX_W] + IDX_W'(1);
            end
        end
        ages_out[int'(way)*IDX_W +: IDX_W] = '0;
    end

endmodule

// File: rtl/repl_policy_unit.sv
// rtl/repl_policy_unit.sv - per-set age ordering and one-hot victim selection (FIFO or LRU)
module repl_policy_unit
    import repl_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 256,
    parameter int MODE = MODE_FIFO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [clog2(SETS)-1:0]   req_set,
    input  logic [WAYS-1:0]          req_vbits,
    output logic                     resp_valid,
    output logic [WAYS-1:0]          resp_way,
    output logic [clog2(WAYS)-1:0]   resp_way_idx,
    input  logic                     touch_valid,
    output logic                     touch_ready,
    input  logic [clog2(SETS)-1:0]   touch_set,
    input  logic [clog2(WAYS)-1:0]   touch_way
);

    localparam int IDX_W = clog2(WAYS);
    localparam int SET_W = clog2(SETS);
    localparam int AGE_W = age_vec_w(WAYS);

    function automatic logic [AGE_W-1:0] reset_ages();
        logic [AGE_W-1:0] a;
        a = '0;
        for (int w = 0; w < WAYS; w++) begin
            a[w*IDX_W +: IDX_W] = IDX_W'(w);
        end
        return a;
    endfunction

    localparam logic [AGE_W-1:0] AGE_INIT = reset_ages();

    repl_state_e      state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [WAYS-1:0]  vbits_q, vbits_d;
    logic [WAYS-1:0]  way_q, way_d;
    logic [IDX_W-1:0] way_idx_q, way_idx_d;
    logic [AGE_W-1:0] age_q [SETS];
    logic [AGE_W-1:0] age_d [SETS];

    logic [AGE_W-1:0] cur_ages;
    logic [AGE_W-1:0] alloc_ages;
    logic [AGE_W-1:0] touch_ages;
    logic [IDX_W-1:0] victim_idx;
    logic             touch_fire;

    assign cur_ages = age_q[set_q];

    // Descending scans so the lowest matching way wins; no match leaves way 0.
    always_comb begin
        victim_idx = '0;
        if (!(&vbits_q)) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!vbits_q[w]) begin
                    victim_idx = IDX_W'(w);
                end
            end
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (cur_ages[w*IDX_W +: IDX_W] == IDX_W'(WAYS - 1)) begin
                    victim_idx = IDX_W'(w);
                end
            end
        end
    end

    // Commit reads ages after any touch written at the CALC edge, with the victim latched in CALC.
    repl_age_update #(.WAYS(WAYS)) u_alloc_update (
        .ages_in  (cur_ages),
        .way      (way_idx_q),
        .ages_out (alloc_ages)
    );

    repl_age_update #(.WAYS(WAYS)) u_touch_update (
        .ages_in  (age_q[touch_set]),
        .way      (touch_way),
        .ages_out (touch_ages)
    );

    assign touch_ready  = (state_q != ST_COMMIT);
    assign touch_fire   = touch_valid && touch_ready && (MODE == MODE_LRU);
    assign resp_way     = way_q;
    assign resp_way_idx = way_idx_q;

    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        vbits_d    = vbits_q;
        way_d      = way_q;
        way_idx_d  = way_idx_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    set_d   = req_set;
                    vbits_d = req_vbits;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                way_idx_d = victim_idx;
                way_d     = WAYS'(1) << victim_idx;
                state_d   = ST_COMMIT;
            end
            ST_COMMIT: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Touch and commit never target the same cycle: touch_ready is low in COMMIT.
    always_comb begin
        age_d = age_q;
        if (touch_fire) begin
            age_d[touch_set] = touch_ages;
        end
        if (state_q == ST_COMMIT) begin
            age_d[set_q] = alloc_ages;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            set_q     <= '0;
            vbits_q   <= '0;
            way_q     <= '0;
            way_idx_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                age_q[s] <= AGE_INIT;
            end
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            vbits_q   <= vbits_d;
            way_q     <= way_d;
            way_idx_q <= way_idx_d;
            age_q     <= age_d;
        end
    end

endmodule

// File: tb/tb_repl_policy_unit.sv
// tb/tb_repl_policy_unit.sv - directed vector bench for FIFO and LRU instances of repl_policy_unit
module tb_repl_policy_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid   [2];
    logic [7:0] req_set     [2];
    logic [3:0] req_vbits   [2];
    logic       touch_valid [2];
    logic [7:0] touch_set   [2];
    logic [1:0] touch_way   [2];

    logic       req_ready0, req_ready1, resp_valid0, resp_valid1, touch_ready0, touch_ready1;
    logic [3:0] resp_way0, resp_way1;
    logic [1:0] resp_idx0, resp_idx1;

    int total = 0;
    int bad   = 0;

    repl_policy_unit #(.WAYS(4), .SETS(256), .MODE(0)) dut_fifo (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready0), .req_set(req_set[0]), .req_vbits(req_vbits[0]),
        .resp_valid(resp_valid0), .resp_way(resp_way0), .resp_way_idx(resp_idx0),
        .touch_valid(touch_valid[0]), .touch_ready(touch_ready0), .touch_set(touch_set[0]),
        .touch_way(touch_way[0])
    );

    repl_policy_unit #(.WAYS(4), .SETS(256), .MODE(1)) dut_lru (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready1), .req_set(req_set[1]), .req_vbits(req_vbits[1]),
        .resp_valid(resp_valid1), .resp_way(resp_way1), .resp_way_idx(resp_idx1),
        .touch_valid(touch_valid[1]), .touch_ready(touch_ready1), .touch_set(touch_set[1]),
        .touch_way(touch_way[1])
    );

    function automatic logic f_rdy(input int m);
        return (m != 0) ? req_ready1 : req_ready0;
    endfunction
    function automatic logic f_vld(input int m);
        return (m != 0) ? resp_valid1 : resp_valid0;
    endfunction
    function automatic logic f_trdy(input int m);
        return (m != 0) ? touch_ready1 : touch_ready0;
    endfunction
    function automatic logic [3:0] f_way(input int m);
        return (m != 0) ? resp_way1 : resp_way0;
    endfunction
    function automatic logic [1:0] f_idx(input int m);
        return (m != 0) ? resp_idx1 : resp_idx0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic do_touch(input int m, input logic [7:0] set, input logic [1:0] way);
        touch_valid[m] = 1'b1;
        touch_set[m]   = set;
        touch_way[m]   = way;
        check($sformatf("touch_rdy m%0d", m), 32'(f_trdy(m)), 1);
        @(posedge clk); #1;
        touch_valid[m] = 1'b0;
    endtask

    task automatic do_req(input int m, input logic [7:0] set, input logic [3:0] vbits,
                          input int exp, input string name);
        logic [3:0] exp_way;
        exp_way = 4'b0001 << exp;
        req_valid[m] = 1'b1;
        req_set[m]   = set;
        req_vbits[m] = vbits;
        check({name, ".idle_rdy"}, 32'(f_rdy(m)), 1);
        @(posedge clk); #1;
        req_valid[m] = 1'b0;
        check({name, ".calc_vld"}, 32'(f_vld(m)), 0);
        check({name, ".calc_rdy"}, 32'(f_rdy(m)), 0);
        @(posedge clk); #1;
        check({name, ".vld"}, 32'(f_vld(m)), 1);
        check({name, ".idx"}, 32'(f_idx(m)), 32'(exp));
        check({name, ".way"}, 32'(f_way(m)), 32'(exp_way));
        check({name, ".commit_rdy"}, 32'(f_rdy(m)), 0);
        @(posedge clk); #1;
        check({name, ".vld_drop"}, 32'(f_vld(m)), 0);
        check({name, ".idx_hold"}, 32'(f_idx(m)), 32'(exp));
    endtask

    typedef struct {
        int         m;
        bit         tch;
        logic [7:0] tset;
        logic [1:0] tway;
        logic [7:0] set;
        logic [3:0] vbits;
        int         exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{0, 1'b0, 8'd0, 2'd0, 8'd5, 4'b0000, 0};
        vecs[1]  = '{0, 1'b0, 8'd0, 2'd0, 8'd5, 4'b1111, 3};
        vecs[2]  = '{0, 1'b0, 8'd0, 2'd0, 8'd7, 4'b1111, 3};
        vecs[3]  = '{0, 1'b1, 8'd7, 2'd0, 8'd7, 4'b1111, 2};
        vecs[4]  = '{0, 1'b1, 8'd7, 2'd0, 8'd7, 4'b1111, 1};
        vecs[5]  = '{0, 1'b1, 8'd7, 2'd0, 8'd7, 4'b1111, 0};
        vecs[6]  = '{1, 1'b1, 8'd9, 2'd3, 8'd9, 4'b1111, 2};
        vecs[7]  = '{1, 1'b1, 8'd9, 2'd2, 8'd9, 4'b1111, 1};
        vecs[8]  = '{1, 1'b0, 8'd0, 2'd0, 8'd9, 4'b1011, 2};
        vecs[9]  = '{0, 1'b0, 8'd0, 2'd0, 8'd7, 4'b1011, 2};
        vecs[10] = '{1, 1'b0, 8'd0, 2'd0, 8'd3, 4'b0110, 0};
        vecs[11] = '{1, 1'b0, 8'd0, 2'd0, 8'd3, 4'b1110, 0};
        vecs[12] = '{1, 1'b0, 8'd0, 2'd0, 8'd3, 4'b1111, 3};

        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req_valid[m] = 1'b0; req_set[m] = '0; req_vbits[m] = '0;
            touch_valid[m] = 1'b0; touch_set[m] = '0; touch_way[m] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("reset.vld m%0d", m),  32'(f_vld(m)),  0);
            check($sformatf("reset.way m%0d", m),  32'(f_way(m)),  0);
            check($sformatf("reset.idx m%0d", m),  32'(f_idx(m)),  0);
            check($sformatf("reset.rdy m%0d", m),  32'(f_rdy(m)),  1);
            check($sformatf("reset.trdy m%0d", m), 32'(f_trdy(m)), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].tch) do_touch(vecs[i].m, vecs[i].tset, vecs[i].tway);
            do_req(vecs[i].m, vecs[i].set, vecs[i].vbits, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Touch held through COMMIT of the same set is refused, then taken in IDLE.
        req_valid[1] = 1'b1; req_set[1] = 8'd9; req_vbits[1] = 4'b1111;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("commit_touch.vld", 32'(resp_valid1), 1);
        check("commit_touch.idx", 32'(resp_idx1), 0);
        touch_valid[1] = 1'b1; touch_set[1] = 8'd9; touch_way[1] = 2'd3;
        check("commit_touch.trdy_low", 32'(touch_ready1), 0);
        @(posedge clk); #1;
        check("commit_touch.trdy_high", 32'(touch_ready1), 1);
        @(posedge clk); #1;
        touch_valid[1] = 1'b0;
        do_req(1, 8'd9, 4'b1111, 1, "commit_touch.after");

        // Touch during CALC: victim from pre-touch ages, commit merges onto post-touch ages.
        req_valid[1] = 1'b1; req_set[1] = 8'd9; req_vbits[1] = 4'b1111;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        touch_valid[1] = 1'b1; touch_set[1] = 8'd9; touch_way[1] = 2'd0;
        check("calc_touch.trdy", 32'(touch_ready1), 1);
        @(posedge clk); #1;
        touch_valid[1] = 1'b0;
        check("calc_touch.vld", 32'(resp_valid1), 1);
        check("calc_touch.idx", 32'(resp_idx1), 2);
        @(posedge clk); #1;
        do_req(1, 8'd9, 4'b1111, 3, "calc_touch.seq0");
        do_req(1, 8'd9, 4'b1111, 1, "calc_touch.seq1");
        do_req(1, 8'd9, 4'b1111, 0, "calc_touch.seq2");
        do_req(1, 8'd9, 4'b1111, 2, "calc_touch.seq3");

        // Asynchronous reset while the FIFO instance is in CALC.
        req_valid[0] = 1'b1; req_set[0] = 8'd5; req_vbits[0] = 4'b1111;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("areset.way", 32'(resp_way0), 0);
        check("areset.idx", 32'(resp_idx0), 0);
        check("areset.vld", 32'(resp_valid0), 0);
        check("areset.rdy", 32'(req_ready0), 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("areset.no_pulse%0d", c), 32'(resp_valid0), 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 8'd7, 4'b0000, 0, "areset.empty");
        do_req(0, 8'd7, 4'b1111, 3, "areset.fifo_init");
        do_req(1, 8'd3, 4'b1111, 3, "areset.lru_init");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
